exception_sequencer: RTL and testbench

Downstream consumer of the interrupt controller: on an asserted jump-to-ISR it saves machine state into the exception special-purpose registers (ESR, ECA, EPC, EDATA, ELEVEL), clears SR, and redirects fetch to the service routine. It also implements `eret` (restore SR, return to EPC) and the `movg2s`/`movs2g` SPR access path. It owns SR, whose output feeds back into the interrupt controller's masking.

---
 rtl/exception_sequencer_pkg.sv | 28 ++
 rtl/exception_sequencer_if.sv | 9 +
 rtl/exception_sequencer_spr_file.sv | 96 +++++++++
 rtl/exception_sequencer.sv | 93 +++++++++
 tb/tb_exception_sequencer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/exception_sequencer_pkg.sv
// rtl/exception_sequencer_pkg.sv - shared constants and types for the exception sequencer
package exception_pkg;

    localparam int unsigned NCAUSE_DEF = 23;
    localparam logic [31:0] SISR_DEF   = 32'h0000_0000;

    localparam logic [2:0] SPR_SR     = 3'd0;
    localparam logic [2:0] SPR_ESR    = 3'd1;
    localparam logic [2:0] SPR_ECA    = 3'd2;
    localparam logic [2:0] SPR_EPC    = 3'd3;
    localparam logic [2:0] SPR_EDATA  = 3'd4;
    localparam logic [2:0] SPR_ELEVEL = 3'd5;

    localparam logic [4:0] IL_RESET     = 5'd0;
    localparam logic [4:0] IL_REPEAT_LO = 5'd16;
    localparam logic [4:0] IL_REPEAT_HI = 5'd20;

    typedef enum logic {
        ST_IDLE,
        ST_REDIRECT
    } state_e;

    // Repeat-class causes re-execute the faulting instruction on return.
    function automatic logic is_repeat(input logic [4:0] il);
        return (il >= IL_REPEAT_LO) && (il <= IL_REPEAT_HI);
    endfunction

endpackage

// File: rtl/exception_sequencer_if.sv
// rtl/exception_sequencer_if.sv - fetch redirect handshake between sequencer and fetch
interface exception_sequencer_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport master (output redirect_valid, output redirect_pc, input redirect_ready);
    modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/exception_sequencer_spr_file.sv
// rtl/exception_sequencer_spr_file.sv - exception SPR storage, prioritised write port and read mux
module spr_file
    import exception_pkg::*;
#(
    parameter int unsigned NCAUSE = NCAUSE_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic              jisr_i,
    input  logic              eret_i,
    input  logic              movg2s_i,
    input  logic [4:0]        il_i,
    input  logic [NCAUSE-1:0] mca_i,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       pc_next_i,
    input  logic [31:0]       ea_i,
    input  logic [2:0]        spr_addr_i,
    input  logic [31:0]       gpr_wdata_i,
    output logic [31:0]       sr_o,
    output logic [31:0]       epc_o,
    output logic [31:0]       spr_rdata_o
);

    logic [31:0]       sr_q, sr_d, esr_q, esr_d, epc_q, epc_d, edata_q, edata_d;
    logic [NCAUSE-1:0] eca_q, eca_d;
    logic [4:0]        elevel_q, elevel_d;

    always_comb begin
        sr_d     = sr_q;
        esr_d    = esr_q;
        eca_d    = eca_q;
        epc_d    = epc_q;
        edata_d  = edata_q;
        elevel_d = elevel_q;
        if (en_i) begin
            if (jisr_i) begin
                sr_d = '0;
                // A reset cause has no meaningful context to save.
                if (il_i != IL_RESET) begin
                    esr_d    = sr_q;
                    eca_d    = mca_i;
                    elevel_d = il_i;
                    edata_d  = ea_i;
                    epc_d    = is_repeat(il_i) ? pc_i : pc_next_i;
                end
            end else if (eret_i) begin
                sr_d = esr_q;
            end else if (movg2s_i) begin
                case (spr_addr_i)
                    SPR_SR:    sr_d    = gpr_wdata_i;
                    SPR_ESR:   esr_d   = gpr_wdata_i;
                    SPR_ECA:   eca_d   = gpr_wdata_i[NCAUSE-1:0];
                    SPR_EPC:   epc_d   = gpr_wdata_i;
                    SPR_EDATA: edata_d = gpr_wdata_i;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr_q     <= '0;
            esr_q    <= '0;
            eca_q    <= '0;
            epc_q    <= '0;
            edata_q  <= '0;
            elevel_q <= '0;
        end else begin
            sr_q     <= sr_d;
            esr_q    <= esr_d;
            eca_q    <= eca_d;
            epc_q    <= epc_d;
            edata_q  <= edata_d;
            elevel_q <= elevel_d;
        end
    end

    always_comb begin
        spr_rdata_o = '0;
        case (spr_addr_i)
            SPR_SR:     spr_rdata_o = sr_q;
            SPR_ESR:    spr_rdata_o = esr_q;
            SPR_ECA:    spr_rdata_o = {{(32-NCAUSE){1'b0}}, eca_q};
            SPR_EPC:    spr_rdata_o = epc_q;
            SPR_EDATA:  spr_rdata_o = edata_q;
            SPR_ELEVEL: spr_rdata_o = {27'b0, elevel_q};
            default:    spr_rdata_o = '0;
        endcase
    end

    assign sr_o  = sr_q;
    assign epc_o = epc_q;

endmodule

// File: rtl/exception_sequencer.sv
// rtl/exception_sequencer.sv - ISR entry / eret sequencing and fetch redirect handshake
module exception_sequencer
    import exception_pkg::*;
#(
    parameter logic [31:0] SISR   = SISR_DEF,
    parameter int unsigned NCAUSE = NCAUSE_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              jisr_i,
    input  logic [4:0]        il_i,
    input  logic [NCAUSE-1:0] mca_i,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       pc_next_i,
    input  logic [31:0]       ea_i,
    input  logic              eret_i,
    input  logic              movg2s_i,
    input  logic [2:0]        spr_addr_i,
    input  logic [31:0]       gpr_wdata_i,
    output logic [31:0]       spr_rdata_o,
    output logic [31:0]       sr_o,
    output logic              busy_o,
    exception_sequencer_if.master redir
);

    state_e      state_q;
    logic        valid_q;
    logic        busy_q;
    logic [31:0] rpc_q;
    logic [31:0] epc;

    spr_file #(.NCAUSE(NCAUSE)) u_spr_file (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .en_i        (state_q == ST_IDLE),
        .jisr_i      (jisr_i),
        .eret_i      (eret_i),
        .movg2s_i    (movg2s_i),
        .il_i        (il_i),
        .mca_i       (mca_i),
        .pc_i        (pc_i),
        .pc_next_i   (pc_next_i),
        .ea_i        (ea_i),
        .spr_addr_i  (spr_addr_i),
        .gpr_wdata_i (gpr_wdata_i),
        .sr_o        (sr_o),
        .epc_o       (epc),
        .spr_rdata_o (spr_rdata_o)
    );

    // eret targets the EPC value held before this edge, which is what epc shows now.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            rpc_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (jisr_i) begin
                        state_q <= ST_REDIRECT;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        rpc_q   <= SISR;
                    end else if (eret_i) begin
                        state_q <= ST_REDIRECT;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        rpc_q   <= epc;
                    end
                end
                ST_REDIRECT: begin
                    if (redir.redirect_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign redir.redirect_valid = valid_q;
    assign redir.redirect_pc    = rpc_q;
    assign busy_o               = busy_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// tb/tb_exception_sequencer.sv - scoreboard bench for exception_sequencer
module tb_exception_sequencer;

    localparam logic [31:0] SISR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        jisr, eret, movg2s;
    logic [4:0]  il;
    logic [22:0] mca;
    logic [31:0] pc, pc_next, ea, gpr_wdata;
    logic [2:0]  spr_addr;
    logic [31:0] spr_rdata, sr;
    logic        busy;

    exception_sequencer_if rif ();

    exception_sequencer #(.SISR(SISR), .NCAUSE(23)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .jisr_i      (jisr),
        .il_i        (il),
        .mca_i       (mca),
        .pc_i        (pc),
        .pc_next_i   (pc_next),
        .ea_i        (ea),
        .eret_i      (eret),
        .movg2s_i    (movg2s),
        .spr_addr_i  (spr_addr),
        .gpr_wdata_i (gpr_wdata),
        .spr_rdata_o (spr_rdata),
        .sr_o        (sr),
        .busy_o      (busy),
        .redir       (rif.master)
    );

    always #50 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted redirect is matched against the oldest expected target.
    always @(negedge clk) begin
        if (!reset && rif.redirect_valid && rif.redirect_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_redirect: got 0x%08h expected none", rif.redirect_pc);
            end else begin
                check("redirect_pc_sb", rif.redirect_pc, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_spr(input string nm, input logic [2:0] a, input logic [31:0] exp);
        spr_addr = a;
        #1;
        check(nm, spr_rdata, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        movg2s = 1'b1; spr_addr = a; gpr_wdata = d;
        cyc();
        movg2s = 1'b0;
    endtask

    task automatic take_isr(input logic [4:0] l, input logic [22:0] m,
                            input logic [31:0] p, input logic [31:0] pn, input logic [31:0] e);
        jisr = 1'b1; il = l; mca = m; pc = p; pc_next = pn; ea = e;
        exp_q.push_back(SISR);
        cyc();
        jisr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; jisr = 0; eret = 0; movg2s = 0; il = 0; mca = 0;
        pc = 0; pc_next = 0; ea = 0; gpr_wdata = 0; spr_addr = 0;
        rif.redirect_ready = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        check("rst_valid", {31'b0, rif.redirect_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rpc", rif.redirect_pc, 32'd0);
        check("rst_sr", sr, 32'd0);
        chk_spr("rst_epc", 3'd3, 32'd0);

        // External cause, continue class
        wr(3'd0, 32'h2);
        check("sr_write", sr, 32'h2);
        take_isr(5'd1, 23'h2, 32'h100, 32'h104, 32'h1234);
        check("isr1_busy", {31'b0, busy}, 32'd1);
        check("isr1_valid", {31'b0, rif.redirect_valid}, 32'd1);
        check("isr1_rpc", rif.redirect_pc, SISR);
        check("isr1_sr", sr, 32'd0);
        chk_spr("isr1_esr", 3'd1, 32'h2);
        chk_spr("isr1_eca", 3'd2, 32'h2);
        chk_spr("isr1_epc", 3'd3, 32'h104);
        chk_spr("isr1_elevel", 3'd5, 32'd1);
        rif.redirect_ready = 1'b1;
        cyc();
        rif.redirect_ready = 1'b0;
        check("isr1_done_valid", {31'b0, rif.redirect_valid}, 32'd0);
        check("isr1_done_busy", {31'b0, busy}, 32'd0);

        // Page fault, repeat class, with a stalled fetch
        take_isr(5'd18, 23'h4_0000, 32'h200, 32'h204, 32'hDEAD_BEE0);
        movg2s = 1'b1; spr_addr = 3'd0; gpr_wdata = 32'hFF; jisr = 1'b1; il = 5'd2;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", {31'b0, rif.redirect_valid}, 32'd1);
            check("stall_rpc", rif.redirect_pc, SISR);
            cyc();
        end
        movg2s = 1'b0; jisr = 1'b0;
        check("stall_sr_ignored", sr, 32'd0);
        chk_spr("pf_epc", 3'd3, 32'h200);
        chk_spr("pf_edata", 3'd4, 32'hDEAD_BEE0);
        chk_spr("pf_elevel", 3'd5, 32'd18);
        chk_spr("pf_eca", 3'd2, 32'h4_0000);
        rif.redirect_ready = 1'b1;
        cyc();
        rif.redirect_ready = 1'b0;

        // eret with a one-cycle redirect
        wr(3'd1, 32'h7);
        wr(3'd3, 32'h104);
        chk_spr("epc_write", 3'd3, 32'h104);
        eret = 1'b1;
        exp_q.push_back(32'h104);
        rif.redirect_ready = 1'b1;
        cyc();
        eret = 1'b0;
        check("eret_sr", sr, 32'h7);
        check("eret_rpc", rif.redirect_pc, 32'h104);
        cyc();
        check("eret_done_valid", {31'b0, rif.redirect_valid}, 32'd0);

        // eret and jisr together: ISR entry wins
        eret = 1'b1;
        take_isr(5'd3, 23'h8, 32'h300, 32'h304, 32'h0);
        eret = 1'b0;
        check("prio_sr", sr, 32'd0);
        chk_spr("prio_esr", 3'd1, 32'h7);
        chk_spr("prio_epc", 3'd3, 32'h304);
        check("prio_rpc", rif.redirect_pc, SISR);
        cyc();
        rif.redirect_ready = 1'b0;

        // SPR map edges
        wr(3'd3, 32'h40);
        chk_spr("epc_40", 3'd3, 32'h40);
        wr(3'd5, 32'h1F);
        chk_spr("elevel_ro", 3'd5, 32'd3);
        wr(3'd6, 32'hFFFF);
        chk_spr("spr6_zero", 3'd6, 32'd0);
        chk_spr("spr7_zero", 3'd7, 32'd0);

        // Reset cause saves nothing
        wr(3'd0, 32'h9);
        wr(3'd1, 32'h5);
        take_isr(5'd0, 23'h0, 32'h500, 32'h504, 32'h0);
        check("ilr_sr", sr, 32'd0);
        chk_spr("ilr_esr", 3'd1, 32'h5);
        chk_spr("ilr_epc", 3'd3, 32'h40);
        chk_spr("ilr_elevel", 3'd5, 32'd3);
        check("ilr_rpc", rif.redirect_pc, SISR);

        // Reset during REDIRECT discards the in-flight redirect
        reset = 1'b1;
        exp_q.delete();
        cyc();
        reset = 1'b0;
        check("rr_valid", {31'b0, rif.redirect_valid}, 32'd0);
        check("rr_busy", {31'b0, busy}, 32'd0);
        check("rr_sr", sr, 32'd0);
        chk_spr("rr_esr", 3'd1, 32'd0);
        chk_spr("rr_eca", 3'd2, 32'd0);
        chk_spr("rr_epc", 3'd3, 32'd0);
        chk_spr("rr_edata", 3'd4, 32'd0);
        chk_spr("rr_elevel", 3'd5, 32'd0);

        cyc(); cyc();
        check("sb_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
